// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch prediction unit
// Contents: jump_t, branch_type_t, bp_entry_t, 2-bit counter encodings and
// a helper that tells whether a branch funct3 encodes a real branch.
package bp_pkg;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b10
    } jump_t;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_type_t;

    // Entry layout for the default 32-bit, 64-entry configuration.
    localparam int BP_XLEN     = 32;
    localparam int BP_ENTRIES  = 64;
    localparam int BP_IDX_BITS = $clog2(BP_ENTRIES);
    localparam int BP_TAG_BITS = BP_XLEN - BP_IDX_BITS - 2;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_XLEN-1:0]     target;
        logic [1:0]             ctr;
    } bp_entry_t;

    // funct3 010/011 are not branches; they never train or take.
    function automatic logic branch_type_legal(input logic [2:0] funct3);
        return !((funct3 == BR_RSV2) || (funct3 == BR_RSV3));
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch/execute signal bundle of the branch prediction unit
// master: pipeline side (drives PCF and Execute-stage fields, receives prediction/redirect)
// slave:  predictor side (branch_predict_unit)
// Optional BP_PERF_COUNTERS_EN adds BranchCount/MispredCount (slave outputs).
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic            PredTakenF;
    logic [XLEN-1:0] PredTargetF;
    logic            ValidE;
    logic [1:0]      JumpE;
    logic            BranchE;
    logic            ZeroE;
    logic [2:0]      BranchTypeE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] TargetE;
    logic [XLEN-1:0] JalrTargetE;
    logic            PredTakenE;
    logic [XLEN-1:0] PredTargetE;
    logic            RedirectE;
    logic [XLEN-1:0] RedirectPCE;
    logic            BranchTakenE;
`ifdef BP_PERF_COUNTERS_EN
    logic [31:0]     BranchCount;
    logic [31:0]     MispredCount;
`endif

    modport master (
        output PCF, ValidE, JumpE, BranchE, ZeroE, BranchTypeE, PCE, PCPlus4E,
               TargetE, JalrTargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, RedirectE, RedirectPCE, BranchTakenE
`ifdef BP_PERF_COUNTERS_EN
        , input BranchCount, MispredCount
`endif
    );

    modport slave (
        input  PCF, ValidE, JumpE, BranchE, ZeroE, BranchTypeE, PCE, PCPlus4E,
               TargetE, JalrTargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, RedirectE, RedirectPCE, BranchTakenE
`ifdef BP_PERF_COUNTERS_EN
        , output BranchCount, MispredCount
`endif
    );

endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - next-state function of a 2-bit saturating counter
// Ports: ctr (current value), taken (outcome), ctr_next (saturated result, no wrap)
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_STRONG_T) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_STRONG_NT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB/BHT fetch prediction with execute-stage resolve and redirect
// Ports: clk, rst (sync active-high), bus (branch_predict_unit_if.slave):
//   fetch lookup PCF -> PredTakenF/PredTargetF; execute resolve -> RedirectE/RedirectPCE/BranchTakenE.
// Optional BP_PERF_COUNTERS_EN adds 32-bit BranchCount/MispredCount on the bus.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter  int XLEN        = 32,
    parameter  int BHT_ENTRIES = 64,
    localparam int IDX_BITS    = $clog2(BHT_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);

    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    logic                valid_q  [BHT_ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [BHT_ENTRIES];
    logic [XLEN-1:0]     target_q [BHT_ENTRIES];
    logic [1:0]          ctr_q    [BHT_ENTRIES];

    // Instructions are word aligned, so PC[1:0] never participates.
    wire unused_pc_bits = &{1'b0, bus.PCF[1:0], bus.PCE[1:0], bus.JalrTargetE[0]};

    // Fetch lookup: reads the table state before any same-cycle update.
    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0] tag_f;
    logic                hit_f;

    assign idx_f = bus.PCF[IDX_BITS+1:2];
    assign tag_f = bus.PCF[XLEN-1:IDX_BITS+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign bus.PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign bus.PredTargetF = hit_f ? target_q[idx_f] : '0;

    // Execute resolve
    logic            is_jal, is_jalr, is_control, br_legal, cond_taken, taken, mispredict;
    logic [XLEN-1:0] jalr_target, actual_target;

    assign is_jal     = (bus.JumpE == JUMP_JAL);
    assign is_jalr    = (bus.JumpE == JUMP_JALR);
    assign is_control = bus.BranchE || (bus.JumpE != JUMP_NONE);
    assign br_legal   = bus.BranchE && branch_type_legal(bus.BranchTypeE);

    // BLT/BGE/BLTU/BGEU arrive with ZeroE already meaning "compare false".
    always_comb begin
        cond_taken = 1'b0;
        case (bus.BranchTypeE)
            BR_BEQ, BR_BGE, BR_BGEU: cond_taken = bus.ZeroE;
            BR_BNE, BR_BLT, BR_BLTU: cond_taken = !bus.ZeroE;
            default:                 cond_taken = 1'b0;
        endcase
    end

    assign taken         = bus.ValidE && (is_jal || is_jalr || (br_legal && cond_taken));
    assign jalr_target   = {bus.JalrTargetE[XLEN-1:1], 1'b0};
    assign actual_target = is_jalr ? jalr_target : bus.TargetE;

    // The last term catches an entry aliasing onto a non-control instruction.
    assign mispredict = bus.ValidE &&
                        ((taken != bus.PredTakenE) ||
                         (taken && bus.PredTakenE && (actual_target != bus.PredTargetE)) ||
                         (!taken && bus.PredTakenE && !is_control));

    assign bus.RedirectE    = mispredict;
    assign bus.RedirectPCE  = taken ? actual_target : bus.PCPlus4E;
    assign bus.BranchTakenE = taken;

    // Training: JALR is deliberately never entered, its target is data dependent.
    logic [IDX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0] tag_e;
    logic                hit_e, train, alias_clear;
    logic [1:0]          ctr_next;

    assign idx_e       = bus.PCE[IDX_BITS+1:2];
    assign tag_e       = bus.PCE[XLEN-1:IDX_BITS+2];
    assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign train       = bus.ValidE && (br_legal || is_jal);
    assign alias_clear = bus.ValidE && !is_control && bus.PredTakenE && hit_e;

    bp_sat_counter u_sat_counter (
        .ctr      (ctr_q[idx_e]),
        .taken    (taken),
        .ctr_next (ctr_next)
    );

    // Tags and targets need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
        end else if (train) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_next;
                if (taken) target_q[idx_e] <= actual_target;
            end else if (taken) begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= actual_target;
                ctr_q[idx_e]    <= is_jal ? CTR_STRONG_T : CTR_WEAK_T;
            end
        end else if (alias_clear) begin
            valid_q[idx_e] <= 1'b0;
        end
    end

`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] branch_count_q, mispred_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            if (bus.ValidE && is_control) branch_count_q <= branch_count_q + 32'd1;
            if (mispredict) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign bus.BranchCount  = branch_count_q;
    assign bus.MispredCount = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed vector bench for branch_predict_unit
module tb_branch_predict_unit;
    import bp_pkg::*;

    typedef struct {
        logic [31:0] pcf;
        logic        ve;
        logic [1:0]  jmp;
        logic        br;
        logic        zero;
        logic [2:0]  btype;
        logic [31:0] pce;
        logic [31:0] pc4;
        logic [31:0] tgt;
        logic [31:0] jtgt;
        logic        pte;
        logic [31:0] ptge;
        logic        e_ptf;
        logic [31:0] e_ptgt;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_bt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    branch_predict_unit_if #(.XLEN(32)) bus ();

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic [31:0] pcf, input logic ve, input logic [1:0] jmp,
                                input logic br, input logic zero, input logic [2:0] btype,
                                input logic [31:0] pce, input logic [31:0] pc4,
                                input logic [31:0] tgt, input logic [31:0] jtgt,
                                input logic pte, input logic [31:0] ptge,
                                input logic e_ptf, input logic [31:0] e_ptgt,
                                input logic e_red, input logic [31:0] e_rpc, input logic e_bt);
        vec_t v;
        v.pcf = pcf; v.ve = ve; v.jmp = jmp; v.br = br; v.zero = zero; v.btype = btype;
        v.pce = pce; v.pc4 = pc4; v.tgt = tgt; v.jtgt = jtgt; v.pte = pte; v.ptge = ptge;
        v.e_ptf = e_ptf; v.e_ptgt = e_ptgt; v.e_red = e_red; v.e_rpc = e_rpc; v.e_bt = e_bt;
        return v;
    endfunction

    function automatic vec_t idle(input logic [31:0] pcf, input logic e_ptf, input logic [31:0] e_ptgt);
        return mk(pcf, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 32'h0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0,
                  e_ptf, e_ptgt, 1'b0, 32'h4, 1'b0);
    endfunction

    function automatic vec_t brv(input logic [31:0] pcf, input logic [31:0] pce, input logic [2:0] btype,
                                 input logic zero, input logic [31:0] tgt, input logic pte,
                                 input logic [31:0] ptge, input logic e_ptf, input logic [31:0] e_ptgt,
                                 input logic e_red, input logic [31:0] e_rpc, input logic e_bt);
        return mk(pcf, 1'b1, 2'b00, 1'b1, zero, btype, pce, pce + 32'd4, tgt, 32'h0, pte, ptge,
                  e_ptf, e_ptgt, e_red, e_rpc, e_bt);
    endfunction

    task automatic drive(input vec_t v);
        bus.PCF = v.pcf; bus.ValidE = v.ve; bus.JumpE = v.jmp; bus.BranchE = v.br;
        bus.ZeroE = v.zero; bus.BranchTypeE = v.btype; bus.PCE = v.pce; bus.PCPlus4E = v.pc4;
        bus.TargetE = v.tgt; bus.JalrTargetE = v.jtgt; bus.PredTakenE = v.pte;
        bus.PredTargetE = v.ptge;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, "_ptf"},  {31'd0, bus.PredTakenF},   {31'd0, v.e_ptf});
        check({tag, "_ptgt"}, bus.PredTargetF,           v.e_ptgt);
        check({tag, "_red"},  {31'd0, bus.RedirectE},    {31'd0, v.e_red});
        check({tag, "_rpc"},  bus.RedirectPCE,           v.e_rpc);
        check({tag, "_bt"},   {31'd0, bus.BranchTakenE}, {31'd0, v.e_bt});
    endtask

    initial begin
        int exp_bc = 0;
        int exp_mc = 0;
        vec_t v;

        // BEQ at 0x100 -> 0x80: allocate, strengthen, loop exit, saturation at 00
        vecs.push_back(idle(32'h100, 1'b0, 32'h0));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h80,  1'b1));
        vecs.push_back(idle(32'h100, 1'b1, 32'h80));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80,  1'b1));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, 1'b0));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, 1'b0));
        vecs.push_back(idle(32'h100, 1'b0, 32'h80));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b0, 32'h80, 1'b0, 32'h0,  1'b0, 32'h80, 1'b0, 32'h104, 1'b0));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b0, 32'h80, 1'b0, 32'h0,  1'b0, 32'h80, 1'b0, 32'h104, 1'b0));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 32'h80, 1'b1, 32'h80,  1'b1));
        vecs.push_back(idle(32'h100, 1'b0, 32'h80));
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 32'h80, 1'b1, 32'h80,  1'b1));
        // predicted taken with the wrong target
        vecs.push_back(brv(32'h100, 32'h100, 3'd0, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h80,  1'b1));
        // alias: same idx, other tag; then stale-alias clear on a non-control hit
        vecs.push_back(mk(32'h200, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 32'h200, 32'h204, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 32'h0, 1'b0, 32'h204, 1'b0));
        vecs.push_back(mk(32'h100, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 32'h100, 32'h104, 32'h0, 32'h0, 1'b1, 32'h80,
                          1'b1, 32'h80, 1'b1, 32'h104, 1'b0));
        vecs.push_back(idle(32'h100, 1'b0, 32'h0));
        // bubble carrying a taken BEQ: no outcome, no allocation
        vecs.push_back(mk(32'h100, 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 32'h100, 32'h104, 32'h80, 32'h0, 1'b0, 32'h0,
                          1'b0, 32'h0, 1'b0, 32'h104, 1'b0));
        vecs.push_back(idle(32'h100, 1'b0, 32'h0));
        // JAL 0x200 -> 0x400
        vecs.push_back(mk(32'h200, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 32'h200, 32'h204, 32'h400, 32'h0, 1'b0, 32'h0,
                          1'b0, 32'h0, 1'b1, 32'h400, 1'b1));
        vecs.push_back(mk(32'h200, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 32'h200, 32'h204, 32'h400, 32'h0, 1'b1, 32'h400,
                          1'b1, 32'h400, 1'b0, 32'h400, 1'b1));
        vecs.push_back(idle(32'h200, 1'b1, 32'h400));
        // JALR 0x300, rs1+imm = 0x555
        vecs.push_back(mk(32'h300, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0, 32'h300, 32'h304, 32'h999, 32'h555, 1'b0, 32'h0,
                          1'b0, 32'h0, 1'b1, 32'h554, 1'b1));
        vecs.push_back(mk(32'h200, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0, 32'h300, 32'h304, 32'h999, 32'h555, 1'b0, 32'h0,
                          1'b1, 32'h400, 1'b1, 32'h554, 1'b1));
        vecs.push_back(idle(32'h300, 1'b0, 32'h0));
        vecs.push_back(idle(32'h200, 1'b1, 32'h400));
        // remaining branch types, each at its own idx; PCF probes the previous row's allocation
        vecs.push_back(brv(32'h44, 32'h44, 3'd1, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0,    1'b1, 32'h1000, 1'b1));
        vecs.push_back(brv(32'h44, 32'h48, 3'd4, 1'b1, 32'h1100, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h4c,   1'b0));
        vecs.push_back(brv(32'h48, 32'h4c, 3'd5, 1'b1, 32'h1200, 1'b0, 32'h0, 1'b0, 32'h0,    1'b1, 32'h1200, 1'b1));
        vecs.push_back(brv(32'h4c, 32'h50, 3'd7, 1'b0, 32'h1300, 1'b0, 32'h0, 1'b1, 32'h1200, 1'b0, 32'h54,   1'b0));
        vecs.push_back(brv(32'h50, 32'h54, 3'd2, 1'b1, 32'h1400, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 32'h58,   1'b0));
        vecs.push_back(brv(32'h54, 32'h58, 3'd3, 1'b0, 32'h1500, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 32'h5c,   1'b0));
        vecs.push_back(brv(32'h58, 32'h5c, 3'd6, 1'b0, 32'h1600, 1'b0, 32'h0, 1'b0, 32'h0,    1'b1, 32'h1600, 1'b1));
        vecs.push_back(idle(32'h5c, 1'b1, 32'h1600));

        rst = 1'b1;
        drive(idle(32'h100, 1'b0, 32'h0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ptf",  {31'd0, bus.PredTakenF}, 32'd0);
        check("rst_ptgt", bus.PredTargetF, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec($sformatf("row%0d", i), vecs[i]);
            if (vecs[i].ve && (vecs[i].br || vecs[i].jmp != 2'b00)) exp_bc++;
            if (vecs[i].e_red) exp_mc++;
        end

        @(negedge clk);
        drive(idle(32'h200, 1'b1, 32'h400));
        #1;
`ifdef BP_PERF_COUNTERS_EN
        check("perf_branch",  bus.BranchCount,  exp_bc);
        check("perf_mispred", bus.MispredCount, exp_mc);
`endif

        // reset lands on a cycle that would allocate 0x640
        @(negedge clk);
        rst = 1'b1;
        v = brv(32'h640, 32'h640, 3'd0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1);
        drive(v);
        #1;
        check("rstupd_red", {31'd0, bus.RedirectE}, 32'd1);
        check("rstupd_rpc", bus.RedirectPCE, 32'h700);
        @(negedge clk);
        rst = 1'b0;
        drive(idle(32'h640, 1'b0, 32'h0));
        #1;
        check("rstupd_ptf",  {31'd0, bus.PredTakenF}, 32'd0);
        check("rstupd_ptgt", bus.PredTargetF, 32'd0);
        bus.PCF = 32'h200;
        #1;
        check("rstclr_ptf",  {31'd0, bus.PredTakenF}, 32'd0);
        check("rstclr_ptgt", bus.PredTargetF, 32'd0);
`ifdef BP_PERF_COUNTERS_EN
        check("perf_rst_branch",  bus.BranchCount,  32'd0);
        check("perf_rst_mispred", bus.MispredCount, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
